// File: rtl/frame_serializer.sv
// frame_serializer: sends a parallel word as a framed serial stream: start, data, optional parity, stop.
// Build option: define FRAME_SERIALIZER_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module frame_serializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 2,
  parameter int MSB_FIRST    = 1,
  parameter int IDLE_LEVEL   = 1,
  parameter int CHANGE_ONLY  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             frame_sync,
  output logic             busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic IDLE_BIT = (IDLE_LEVEL != 0);

`ifdef FRAME_SERIALIZER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state;
  logic [CW-1:0]     clk_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [WIDTH-1:0]  shreg;
  logic [WIDTH-1:0]  last_sent;
  logic              accept;
`ifdef FRAME_SERIALIZER_PARITY_EN
  logic              parity_bit;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  // data_ready doubles as the "out of reset for a cycle" qualifier in both launch modes
  always_comb begin
    accept = 1'b0;
    if (state == IDLE && data_ready) begin
      if (CHANGE_ONLY != 0) accept = (data_in != last_sent);
      else                  accept = data_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      serial_out <= IDLE_BIT;
      frame_sync <= 1'b0;
      busy       <= 1'b0;
      data_ready <= 1'b0;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      last_sent  <= '0;
    end else begin
      case (state)
        IDLE: begin
          data_ready <= 1'b1;
          serial_out <= IDLE_BIT;
          if (accept) begin
            shreg      <= data_in;
            last_sent  <= data_in;
`ifdef FRAME_SERIALIZER_PARITY_EN
            parity_bit <= ^data_in;
`endif
            state      <= START;
            serial_out <= ~IDLE_BIT;
            frame_sync <= 1'b1;
            busy       <= 1'b1;
            data_ready <= 1'b0;
            clk_cnt    <= '0;
          end
        end
        START: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            state      <= DATA;
            frame_sync <= 1'b0;
            serial_out <= first_bit(shreg);
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
`ifdef FRAME_SERIALIZER_PARITY_EN
              state      <= PARITY;
              serial_out <= parity_bit;
`else
              state      <= STOP;
              serial_out <= IDLE_BIT;
`endif
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              shreg      <= shift_word(shreg);
              serial_out <= first_bit(shift_word(shreg));
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef FRAME_SERIALIZER_PARITY_EN
        PARITY: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt    <= '0;
            state      <= STOP;
            serial_out <= IDLE_BIT;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt    <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
            data_ready <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          serial_out <= IDLE_BIT;
          frame_sync <= 1'b0;
          busy       <= 1'b0;
          data_ready <= 1'b0;
          clk_cnt    <= '0;
        end
      endcase
    end
  end

endmodule
